// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 16-point FFT: default widths, stage FSM states and the
// W16^e twiddle table (e = 0..9) stored as sign plus magnitude in Q2.14.
package fft_pkg;

    localparam int unsigned FFT_N       = 16;
    localparam int unsigned FFT_TW_FRAC = FFT_N - 2;
    // Fraction bits of the stored table; the ROM rescales to the instance's TW_FRAC.
    localparam int unsigned TW_Q        = 14;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StOut
    } state_t;

    typedef struct packed {
        logic          c_neg;
        logic [TW_Q:0] c_mag;
        logic          d_neg;
        logic [TW_Q:0] d_mag;
    } tw_entry_t;

    // W16^e = cos - j sin, so c = cos(2*pi*e/16) and d = -sin(2*pi*e/16).
    function automatic tw_entry_t tw_lookup(input logic [3:0] e);
        unique case (e)
            4'd0:    return '{1'b0, 15'd16384, 1'b0, 15'd0};
            4'd1:    return '{1'b0, 15'd15137, 1'b1, 15'd6270};
            4'd2:    return '{1'b0, 15'd11585, 1'b1, 15'd11585};
            4'd3:    return '{1'b0, 15'd6270,  1'b1, 15'd15137};
            4'd4:    return '{1'b0, 15'd0,     1'b1, 15'd16384};
            4'd5:    return '{1'b1, 15'd6270,  1'b1, 15'd15137};
            4'd6:    return '{1'b1, 15'd11585, 1'b1, 15'd11585};
            4'd7:    return '{1'b1, 15'd15137, 1'b1, 15'd6270};
            4'd8:    return '{1'b1, 15'd16384, 1'b0, 15'd0};
            4'd9:    return '{1'b1, 15'd15137, 1'b0, 15'd6270};
            default: return '{1'b0, 15'd0,     1'b0, 15'd0};
        endcase
    endfunction

endpackage

// File: rtl/multiplier.sv
// Unsigned N x N -> 2N combinational multiplier using radix-4 Booth recoding of operand b.
// N must be even; b is zero-extended so the recoded digits always sum to the unsigned value.
module multiplier #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);

    localparam int unsigned NGROUPS = N / 2 + 1;

    logic [N+2:0]   bx;
    logic [2*N-1:0] ae;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] acc;

    // Arithmetic is modulo 2^(2N); the true product always fits, so the wrap is harmless.
    always_comb begin
        bx  = {2'b00, b, 1'b0};
        ae  = {{N{1'b0}}, a};
        pp  = '0;
        acc = '0;
        for (int i = 0; i < NGROUPS; i++) begin
            unique case (bx[2*i +: 3])
                3'b001, 3'b010: pp = ae;
                3'b011:         pp = ae << 1;
                3'b100:         pp = -(ae << 1);
                3'b101, 3'b110: pp = -ae;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
        p = acc;
    end

endmodule

// File: rtl/twiddle_rom.sv
// Combinational twiddle lookup: exponent e (0..9) -> signed (c, d) of W16^e in Q2.TW_FRAC.
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int unsigned N       = FFT_N,
    parameter int unsigned TW_FRAC = FFT_TW_FRAC
) (
    input  logic [3:0]          e,
    output logic signed [N-1:0] c,
    output logic signed [N-1:0] d
);

    localparam int unsigned SHL = (TW_FRAC > TW_Q) ? TW_FRAC - TW_Q : 0;
    localparam int unsigned SHR = (TW_FRAC < TW_Q) ? TW_Q - TW_FRAC : 0;

    tw_entry_t    ent;
    logic [N-1:0] c_mag;
    logic [N-1:0] d_mag;

    always_comb begin
        ent   = tw_lookup(e);
        c_mag = N'((32'(ent.c_mag) << SHL) >> SHR);
        d_mag = N'((32'(ent.d_mag) << SHL) >> SHR);
        c     = ent.c_neg ? -$signed(c_mag) : $signed(c_mag);
        d     = ent.d_neg ? -$signed(d_mag) : $signed(d_mag);
    end

endmodule

// File: rtl/twiddle_cmul_stage.sv
// Inter-stage twiddle multiplier: sample n = 4p + q is multiplied by W16^(p*q) using one shared
// unsigned multiplier over four cycles. Define TWIDDLE_BYPASS_EN to let e = 0 samples skip MUL.
module twiddle_cmul_stage
    import fft_pkg::*;
#(
    parameter int unsigned N       = FFT_N,
    parameter int unsigned TW_FRAC = N - 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_re,
    input  logic signed [N-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_re,
    output logic signed [N-1:0] out_im,
    output logic [3:0]          out_idx
);

    localparam int unsigned AW = 2 * N + 1;
    localparam logic signed [AW-1:0] RND     = AW'(1) << (TW_FRAC - 1);
    localparam logic signed [AW-1:0] SAT_MAX = {{(N + 2){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(N + 2){1'b1}}, {(N - 1){1'b0}}};

    state_t               state_q, state_d;
    logic [2:0]           k_q, k_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           idx_q, idx_d;
    logic signed [N-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic signed [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic signed [N-1:0]  out_re_q, out_re_d, out_im_q, out_im_d;
    logic [3:0]           out_idx_q, out_idx_d;

    logic [3:0]           cnt_eff;
    logic [3:0]           e;
    logic signed [N-1:0]  tw_c, tw_d;
    logic signed [N-1:0]  op_x, op_y;
    logic [N-1:0]         mag_x, mag_y;
    logic [2*N-1:0]       prod;
    logic                 prod_neg;
    logic [AW-1:0]        prod_ext;
    logic signed [AW-1:0] term;

    // Round half toward +inf, then clamp to the N-bit signed range.
    function automatic logic signed [N-1:0] round_sat(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] r;
        r = (acc + RND) >>> TW_FRAC;
        if (r > SAT_MAX) return SAT_MAX[N-1:0];
        if (r < SAT_MIN) return SAT_MIN[N-1:0];
        return r[N-1:0];
    endfunction

    assign cnt_eff = frame_clr ? 4'd0 : cnt_q;
    assign e       = 4'(cnt_eff[3:2]) * 4'(cnt_eff[1:0]);

    twiddle_rom #(
        .N       (N),
        .TW_FRAC (TW_FRAC)
    ) u_rom (
        .e (e),
        .c (tw_c),
        .d (tw_d)
    );

    // Product schedule: k0 a*c, k1 b*d (subtracted), k2 a*d, k3 b*c.
    always_comb begin
        op_x     = (k_q == 3'd0 || k_q == 3'd2) ? a_q : b_q;
        op_y     = (k_q == 3'd0 || k_q == 3'd3) ? c_q : d_q;
        mag_x    = op_x[N-1] ? -op_x : op_x;
        mag_y    = op_y[N-1] ? -op_y : op_y;
        prod_neg = op_x[N-1] ^ op_y[N-1] ^ (k_q == 3'd1);
        prod_ext = {1'b0, prod};
        term     = prod_neg ? -$signed(prod_ext) : $signed(prod_ext);
    end

    multiplier #(
        .N (N)
    ) u_mul (
        .a (mag_x),
        .b (mag_y),
        .p (prod)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        d_d       = d_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        out_re_d  = out_re_q;
        out_im_d  = out_im_q;
        out_idx_d = out_idx_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = cnt_eff;
                if (in_valid) begin
                    a_d      = in_re;
                    b_d      = in_im;
                    c_d      = tw_c;
                    d_d      = tw_d;
                    idx_d    = cnt_eff;
                    cnt_d    = cnt_eff + 4'd1;
                    acc_re_d = '0;
                    acc_im_d = '0;
                    k_d      = 3'd0;
                    state_d  = StMul;
`ifdef TWIDDLE_BYPASS_EN
                    if (e == 4'd0) begin
                        out_re_d  = in_re;
                        out_im_d  = in_im;
                        out_idx_d = cnt_eff;
                        state_d   = StOut;
                    end
`endif
                end
            end
            StMul: begin
                if (k_q < 3'd4) begin
                    if (k_q[1]) acc_im_d = acc_im_q + term;
                    else        acc_re_d = acc_re_q + term;
                    k_d = k_q + 3'd1;
                end else begin
                    // Extra cycle after k3 rounds the settled accumulators.
                    out_re_d  = round_sat(acc_re_q);
                    out_im_d  = round_sat(acc_im_q);
                    out_idx_d = idx_q;
                    state_d   = StOut;
                end
            end
            StOut: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            k_q       <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            out_re_q  <= '0;
            out_im_q  <= '0;
            out_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
            acc_re_q  <= acc_re_d;
            acc_im_q  <= acc_im_d;
            out_re_q  <= out_re_d;
            out_im_q  <= out_im_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StOut);
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_idx   = out_idx_q;

endmodule
